// File: rtl/gate_tb_pkg.sv
// ---------------------------------------------------------------------------
// gate_tb_pkg
// Shared definitions for the gate vector sequencer:
//   state_e      - sequencer FSM states
//   OP_*         - reference-function selector codes
//   num_vectors  - number of input combinations for an N-input gate (2^n)
// ---------------------------------------------------------------------------
package gate_tb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_NAND = 3;

  function automatic int num_vectors(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// ---------------------------------------------------------------------------
// gate_ref_model
// Combinational golden model of the gate under test: a reduction of the
// applied vector selected by OP.
// Ports:
//   vec      in  N_IN  vector currently applied to the gate
//   expected out 1     reference output for vec
// ---------------------------------------------------------------------------
module gate_ref_model
  import gate_tb_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int OP   = OP_AND
) (
  input  logic [N_IN-1:0] vec,
  output logic            expected
);

  always_comb begin
    expected = 1'b0;
    case (OP)
      OP_AND:  expected = &vec;
      OP_OR:   expected = |vec;
      OP_XOR:  expected = ^vec;
      OP_NAND: expected = ~&vec;
      default: expected = &vec;
    endcase
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// ---------------------------------------------------------------------------
// gate_vector_sequencer
// Exhaustive stimulus/check stage for a small combinational gate. Sweeps every
// N_IN-bit vector in ascending order, holds each for HOLD_CYCLES clocks,
// samples the gate output on the last clock of each hold and compares it
// against gate_ref_model.
//
// state | meaning
// IDLE  | vec parked at 0, waiting for start
// APPLY | driving vectors, counting hold clocks, comparing at end of hold
// DONE  | one-cycle done pulse, pass valid; returns to IDLE
//
// Ports:
//   clk              in  1      rising-edge clock
//   rst_n            in  1      asynchronous active-low reset
//   start            in  1      starts a sweep when sampled in IDLE
//   abort            in  1      ends a running sweep without done
//   dut_out          in  1      output of the gate under test
//   vec              out N_IN   vector driven to the gate (MSB = "a")
//   busy             out 1      sweep in progress
//   done             out 1      one-cycle completion pulse
//   pass             out 1      last completed sweep had no mismatches
//   err_count        out N_IN+1 mismatch count of current/last sweep
//   first_fail_vec   out N_IN   first mismatching vector
//   first_fail_valid out 1      first_fail_vec is meaningful
// ---------------------------------------------------------------------------
module gate_vector_sequencer
  import gate_tb_pkg::*;
#(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int OP          = OP_AND
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_out,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int                HW        = $clog2(HOLD_CYCLES);
  localparam int                NVEC      = num_vectors(N_IN);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0]   VEC_LAST  = N_IN'(NVEC - 1);

  state_e            state_q;
  logic [HW-1:0]     hold_cnt_q;
  logic [N_IN-1:0]   vec_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [N_IN:0]     err_count_q;
  logic [N_IN-1:0]   first_fail_vec_q;
  logic              first_fail_valid_q;

  logic              ref_out;
  logic              mismatch;
  logic [N_IN:0]     err_count_d;

  gate_ref_model #(
    .N_IN (N_IN),
    .OP   (OP)
  ) u_ref (
    .vec      (vec_q),
    .expected (ref_out)
  );

  // err_count cannot exceed 2^N_IN, so N_IN+1 bits never wrap.
  always_comb begin
    mismatch    = (dut_out != ref_out);
    err_count_d = mismatch ? (err_count_q + (N_IN + 1)'(1)) : err_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      hold_cnt_q         <= '0;
      vec_q              <= '0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      err_count_q        <= '0;
      first_fail_vec_q   <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q            <= APPLY;
            vec_q              <= '0;
            hold_cnt_q         <= '0;
            busy_q             <= 1'b1;
            err_count_q        <= '0;
            first_fail_valid_q <= 1'b0;
            pass_q             <= 1'b0;
          end
        end

        APPLY: begin
          // abort takes priority even over the final compare edge.
          if (abort) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            err_count_q <= err_count_d;
            if (mismatch && !first_fail_valid_q) begin
              first_fail_vec_q   <= vec_q;
              first_fail_valid_q <= 1'b1;
            end
            hold_cnt_q <= '0;
            if (vec_q != VEC_LAST) begin
              vec_q <= vec_q + N_IN'(1);
            end else begin
              // pass uses err_count_d so a miss on the last vector counts.
              state_q <= DONE;
              vec_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_d == '0);
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign vec              = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_count_q;
  assign first_fail_vec   = first_fail_vec_q;
  assign first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
module tb_gate_vector_sequencer;

  localparam int NDUT = 4;
  localparam int NI_T [NDUT] = '{3, 2, 4, 2};
  localparam int HC_T [NDUT] = '{4, 2, 3, 5};
  localparam int OP_T [NDUT] = '{0, 2, 3, 1};

  logic        clk;
  logic        rst_n;
  logic        start_s   [NDUT];
  logic        abort_s   [NDUT];
  logic [15:0] tt        [NDUT];
  logic [7:0]  vec_w     [NDUT];
  logic        busy_w    [NDUT];
  logic        done_w    [NDUT];
  logic        pass_w    [NDUT];
  logic [8:0]  err_w     [NDUT];
  logic [7:0]  ffv_w     [NDUT];
  logic        ffvalid_w [NDUT];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int NI = NI_T[g];
    logic [NI-1:0] v;
    logic [NI:0]   e;
    logic [NI-1:0] f;
    logic          dout;

    // Gate under test modelled as a truth table indexed by the applied vector.
    assign dout = tt[g][v];

    gate_vector_sequencer #(
      .N_IN        (NI),
      .HOLD_CYCLES (HC_T[g]),
      .OP          (OP_T[g])
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start_s[g]),
      .abort            (abort_s[g]),
      .dut_out          (dout),
      .vec              (v),
      .busy             (busy_w[g]),
      .done             (done_w[g]),
      .pass             (pass_w[g]),
      .err_count        (e),
      .first_fail_vec   (f),
      .first_fail_valid (ffvalid_w[g])
    );

    assign vec_w[g] = 8'(v);
    assign err_w[g] = 9'(e);
    assign ffv_w[g] = 8'(f);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference function written from the gate definitions: count ones.
  function automatic bit ref_bit(input int op, input int v, input int n);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += (v >> i) & 1;
    case (op)
      0:       return ones == n;
      1:       return ones > 0;
      2:       return (ones % 2) == 1;
      default: return ones != n;
    endcase
  endfunction

  task automatic expect_first(input int sel, input logic [15:0] tt_v, input int nvec_done,
                              output int exp_err, output int exp_ffv, output bit exp_ffvalid);
    exp_err = 0; exp_ffv = 0; exp_ffvalid = 0;
    for (int v = 0; v < nvec_done; v++) begin
      if (tt_v[v] != ref_bit(OP_T[sel], v, NI_T[sel])) begin
        if (!exp_ffvalid) begin
          exp_ffv     = v;
          exp_ffvalid = 1;
        end
        exp_err++;
      end
    end
  endtask

  task automatic run_sweep(input int sel, input logic [15:0] tt_v, input string tag);
    int n        = NI_T[sel];
    int hold     = HC_T[sel];
    int nv       = 1 << n;
    int total    = nv * hold;
    int exp_err;
    int exp_ffv;
    bit exp_ffvalid;
    int done_cyc = -1;
    bit seq_bad  = 0;
    expect_first(sel, tt_v, nv, exp_err, exp_ffv, exp_ffvalid);
    @(negedge clk);
    tt[sel]      = tt_v;
    start_s[sel] = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_start_busy"}, busy_w[sel], 1);
    chk({tag, "_start_err"}, err_w[sel], 0);
    @(negedge clk);
    start_s[sel] = 1'b0;
    for (int c = 1; c <= total + 8; c++) begin
      @(posedge clk); #1;
      if (done_w[sel]) begin
        done_cyc = c;
        break;
      end
      if (vec_w[sel] != 8'(c / hold) || busy_w[sel] !== 1'b1) seq_bad = 1;
    end
    chk({tag, "_latency"}, done_cyc, total);
    chk({tag, "_vec_seq"}, seq_bad, 0);
    chk({tag, "_done_busy"}, busy_w[sel], 0);
    chk({tag, "_done_vec"}, vec_w[sel], 0);
    chk({tag, "_pass"}, pass_w[sel], (exp_err == 0));
    chk({tag, "_err"}, err_w[sel], exp_err);
    chk({tag, "_ffvalid"}, ffvalid_w[sel], exp_ffvalid);
    if (exp_ffvalid) chk({tag, "_ffv"}, ffv_w[sel], exp_ffv);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done_w[sel], 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold_err"}, err_w[sel], exp_err);
    chk({tag, "_hold_pass"}, pass_w[sel], (exp_err == 0));
  endtask

  // Abort sampled at edge k+a, where k is the start edge (a >= 2).
  task automatic run_abort(input int sel, input int a, input logic [15:0] tt_v,
                           input bit chk_err, input string tag);
    int hold  = HC_T[sel];
    int total = (1 << NI_T[sel]) * hold;
    int exp_err;
    int exp_ffv;
    bit exp_ffvalid;
    bit done_seen = 0;
    expect_first(sel, tt_v, (a - 1) / hold, exp_err, exp_ffv, exp_ffvalid);
    @(negedge clk);
    tt[sel]      = tt_v;
    start_s[sel] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start_s[sel] = 1'b0;
    repeat (a - 1) @(posedge clk);
    #1;
    chk({tag, "_pre_vec"}, vec_w[sel], (a - 1) / hold);
    @(negedge clk);
    abort_s[sel] = 1'b1;
    @(posedge clk); #1;
    if (done_w[sel]) done_seen = 1;
    chk({tag, "_busy"}, busy_w[sel], 0);
    chk({tag, "_vec"}, vec_w[sel], 0);
    @(negedge clk);
    abort_s[sel] = 1'b0;
    for (int c = 0; c < total + 4; c++) begin
      @(posedge clk); #1;
      if (done_w[sel]) done_seen = 1;
    end
    chk({tag, "_no_done"}, done_seen, 0);
    chk({tag, "_pass"}, pass_w[sel], 0);
    chk({tag, "_idle_busy"}, busy_w[sel], 0);
    if (chk_err) begin
      chk({tag, "_err"}, err_w[sel], exp_err);
      chk({tag, "_ffvalid"}, ffvalid_w[sel], exp_ffvalid);
      if (exp_ffvalid) chk({tag, "_ffv"}, ffv_w[sel], exp_ffv);
    end
  endtask

  task automatic check_zero(input int sel, input string tag);
    chk({tag, "_vec"}, vec_w[sel], 0);
    chk({tag, "_busy"}, busy_w[sel], 0);
    chk({tag, "_done"}, done_w[sel], 0);
    chk({tag, "_pass"}, pass_w[sel], 0);
    chk({tag, "_err"}, err_w[sel], 0);
    chk({tag, "_ffv"}, ffv_w[sel], 0);
    chk({tag, "_ffvalid"}, ffvalid_w[sel], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    int done_at;
    int second_done;
    bit seen;
    rst_n = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      start_s[g] = 1'b0;
      abort_s[g] = 1'b0;
      tt[g]      = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) check_zero(g, $sformatf("reset%0d", g));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 3-input AND: correct, stuck-at-0, stuck-at-1, then random faults.
    run_sweep(0, 16'h0080, "and_ok");
    run_sweep(0, 16'h0000, "and_sa0");
    run_sweep(0, 16'h00ff, "and_sa1");
    for (int i = 0; i < 3; i++) run_sweep(0, 16'($urandom()), $sformatf("and_rnd%0d", i));

    // start held high for 40 cycles with a stuck-at-1 gate.
    @(negedge clk);
    tt[0]      = 16'h00ff;
    start_s[0] = 1'b1;
    @(posedge clk);
    done_cnt    = 0;
    done_at     = -1;
    second_done = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (done_w[0]) begin
        if (c <= 40) begin
          done_cnt++;
          done_at = c;
        end else if (second_done < 0) begin
          second_done = c;
        end
      end
      if (c == 34) begin
        chk("held_restart_busy", busy_w[0], 1);
        chk("held_restart_err", err_w[0], 0);
      end
      if (c == 40) begin
        @(negedge clk);
        start_s[0] = 1'b0;
      end
    end
    chk("held_done_count", done_cnt, 1);
    chk("held_done_at", done_at, 32);
    chk("held_second_done", second_done, 66);
    chk("held_second_err", err_w[0], 7);
    chk("held_second_pass", pass_w[0], 0);
    repeat (3) @(posedge clk);

    // Aborts: fixed at cycle 10, random, and coincident with the final compare.
    run_abort(0, 10, 16'h00ff, 1, "abort10");
    run_abort(2, 2 + int'($urandom_range(40)), 16'($urandom()), 1, "abort_rnd");
    run_abort(2, 48, 16'h0000, 0, "abort_last");

    // Abort while idle has no effect.
    @(negedge clk);
    abort_s[0] = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_busy", busy_w[0], 0);
    @(negedge clk);
    abort_s[0] = 1'b0;

    // Asynchronous reset in the middle of a sweep.
    @(negedge clk);
    tt[0]      = 16'h00ff;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("rst_pre_busy", busy_w[0], 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero(0, "rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_w[0] || busy_w[0]) seen = 1;
    end
    chk("rst_no_resume", seen, 0);
    check_zero(0, "rst_after");

    // 2-input XOR reference: correct XOR gate, then an AND gate.
    run_sweep(1, 16'h0006, "xor_ok");
    run_sweep(1, 16'h0008, "xor_and");
    run_sweep(1, 16'($urandom()), "xor_rnd");

    // NAND and OR configurations with random gates.
    run_sweep(2, 16'h7fff, "nand_ok");
    for (int i = 0; i < 2; i++) run_sweep(2, 16'($urandom()), $sformatf("nand_rnd%0d", i));
    run_sweep(3, 16'h000e, "or_ok");
    for (int i = 0; i < 2; i++) run_sweep(3, 16'($urandom()), $sformatf("or_rnd%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
